// File: rtl/seq_divider_25x9_if.sv
// Handshake and data bundle for the 25/9 restoring divider.
// master = producer/consumer side, slave = divider.
interface seq_divider_25x9_if;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] dividend;
  logic [8:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [8:0]  remainder;
  logic        div_by_zero;
  logic        overflow;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/seq_divider_25x9.sv
// Sequential unsigned restoring divider, 25-bit / 9-bit -> 16-bit quotient,
// 9-bit remainder, one quotient bit per clock.
module seq_divider_25x9 (
  input  logic                  clk,
  input  logic                  rst,
  seq_divider_25x9_if.slave     bus
);
  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

  state_t      state, state_n;
  logic [15:0] dvd_lo;      // only the low 16 bits are shifted in during DIVIDE
  logic [8:0]  dvs_reg;
  logic [9:0]  r_reg;
  logic [15:0] q_reg;
  logic [3:0]  bit_idx;

  logic        accept, err_dbz, err_ovf;
  logic [9:0]  t, t_sub, r_next;
  logic        q_bit;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    accept  = bus.in_valid && (state == IDLE);
    err_dbz = (bus.divisor == 9'd0);
    err_ovf = !err_dbz && (bus.dividend[24:16] >= bus.divisor);
    t       = {r_reg[8:0], dvd_lo[bit_idx]};
    t_sub   = t - {1'b0, dvs_reg};
    q_bit   = (t >= {1'b0, dvs_reg});
    r_next  = q_bit ? t_sub : t;
    case (state)
      IDLE:   if (accept) state_n = (err_dbz || err_ovf) ? DONE : DIVIDE;
      DIVIDE: if (bit_idx == 4'd0) state_n = DONE;
      DONE:   if (bus.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Result fields are loaded only when a result becomes ready, so they hold
  // steady through DONE and afterwards until the next completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_lo          <= '0;
      dvs_reg         <= '0;
      r_reg           <= '0;
      q_reg           <= '0;
      bit_idx         <= '0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
      bus.overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          dvd_lo  <= bus.dividend[15:0];
          dvs_reg <= bus.divisor;
          if (err_dbz || err_ovf) begin
            bus.quotient    <= 16'hFFFF;
            bus.remainder   <= 9'h000;
            bus.div_by_zero <= err_dbz;
            bus.overflow    <= err_ovf;
          end else begin
            r_reg   <= {1'b0, bus.dividend[24:16]};
            q_reg   <= '0;
            bit_idx <= 4'd15;
          end
        end
        DIVIDE: begin
          r_reg   <= r_next;
          q_reg   <= {q_reg[14:0], q_bit};
          bit_idx <= bit_idx - 4'd1;
          if (bit_idx == 4'd0) begin
            bus.quotient    <= {q_reg[14:0], q_bit};
            bus.remainder   <= r_next[8:0];
            bus.div_by_zero <= 1'b0;
            bus.overflow    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider_25x9.sv
// Directed plus randomized checks of seq_divider_25x9 against an arithmetic
// reference model (/ and %).
module tb_seq_divider_25x9;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  seq_divider_25x9_if bus();

  seq_divider_25x9 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division with the error rules.
  task automatic model(input logic [24:0] dvd, input logic [8:0] dvs,
                       output logic [15:0] q, output logic [8:0] r,
                       output logic dbz, output logic ovf);
    longint unsigned a, b;
    a = dvd; b = dvs;
    q = 16'hFFFF; r = 9'h0; dbz = 1'b0; ovf = 1'b0;
    if (b == 0) dbz = 1'b1;
    else if (a >= (b << 16)) ovf = 1'b1;
    else begin
      q = 16'(a / b);
      r = 9'(a % b);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic accept(input logic [24:0] dvd, input logic [8:0] dvs);
    bus.in_valid = 1'b1; bus.dividend = dvd; bus.divisor = dvs;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk); @(negedge clk); n++;
    end
  endtask

  task automatic check_result(input string tag, input logic [24:0] dvd, input logic [8:0] dvs);
    logic [15:0] q; logic [8:0] r; logic dbz, ovf;
    model(dvd, dvs, q, r, dbz, ovf);
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, ".q"},     32'(bus.quotient), 32'(q));
    chk({tag, ".r"},     32'(bus.remainder), 32'(r));
    chk({tag, ".flags"}, {30'd0, bus.div_by_zero, bus.overflow}, {30'd0, dbz, ovf});
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic run_div(input string tag, input logic [24:0] dvd, input logic [8:0] dvs,
                         input bit check_lat);
    int n; logic [15:0] q; logic [8:0] r; logic dbz, ovf;
    model(dvd, dvs, q, r, dbz, ovf);
    accept(dvd, dvs);
    wait_valid(n);
    if (check_lat) chk({tag, ".lat"}, 32'(n), (dbz || ovf) ? 32'd0 : 32'd16);
    check_result(tag, dvd, dvs);
    take();
    chk({tag, ".idle"}, {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
  endtask

  initial begin
    int n;
    logic [15:0] hq; logic [8:0] hr; logic hd, ho;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.dividend = '0; bus.divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset.ready_valid", {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
    chk("reset.q", 32'(bus.quotient), 32'd0);
    chk("reset.r", 32'(bus.remainder), 32'd0);
    chk("reset.flags", {30'd0, bus.div_by_zero, bus.overflow}, 32'd0);

    run_div("inverse", 25'h389B68, 9'h087, 1'b1);
    chk("inverse.q_const", 32'(bus.quotient), 32'h6B58);
    run_div("withrem", 25'h4BD23D, 9'h1A3, 1'b1);
    chk("withrem.r_const", 32'(bus.remainder), 32'h064);
    run_div("maxbound", 25'h1FEFFFF, 9'h1FF, 1'b1);
    run_div("dbz", 25'h0000123, 9'h000, 1'b1);
    run_div("ovf", 25'h1000000, 9'h001, 1'b1);
    run_div("ovf_edge", 25'h0870000, 9'h087, 1'b1);
    run_div("zero_dvd", 25'h0, 9'h005, 1'b1);

    // Backpressure: result held, inputs ignored, no accept on DONE exit.
    accept(25'h4BD23D, 9'h1A3);
    wait_valid(n);
    model(25'h4BD23D, 9'h1A3, hq, hr, hd, ho);
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = k[0]; bus.dividend = 25'($urandom); bus.divisor = 9'($urandom);
      @(posedge clk); @(negedge clk);
      chk("bp.hold", {bus.in_ready, bus.out_valid, bus.quotient, bus.remainder},
          {1'b0, 1'b1, hq, hr});
    end
    bus.in_valid = 1'b1; bus.divisor = 9'h003; bus.dividend = 25'h100;
    take();
    bus.in_valid = 1'b0;
    chk("bp.no_accept", {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
    @(posedge clk); @(negedge clk);
    chk("bp.still_idle", {30'd0, bus.in_ready, bus.out_valid}, 32'b10);

    // Reset mid-divide.
    accept(25'h4BD23D, 9'h1A3);
    repeat (7) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("rst.ready_valid", {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
    chk("rst.fields", {bus.div_by_zero, bus.overflow, bus.quotient, bus.remainder}, 32'd0);
    run_div("after_rst", 25'h389B68, 9'h087, 1'b1);

    // Randomized: half built to be in range, half raw (often errors).
    for (int k = 0; k < 40; k++) begin
      logic [24:0] dvd; logic [8:0] dvs; longint unsigned v;
      if (k[0]) begin
        dvs = 9'($urandom_range(1, 511));
        v = longint'($urandom_range(0, 65535)) * dvs + $urandom_range(0, int'(dvs) - 1);
        dvd = 25'(v);
      end else begin
        dvd = 25'($urandom);
        dvs = 9'($urandom_range(0, 511));
      end
      accept(dvd, dvs);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); @(negedge clk); end
      wait_valid(n);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); @(negedge clk); end
      check_result("rand", dvd, dvs);
      take();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
